// File: rtl/crypto_bus_endpoint_if.sv
// Bus-side signal bundle for crypto_bus_endpoint: transaction, input-data,
// output-data and acknowledge channels, seen from the fabric (master) and the endpoint (slave).
interface crypto_bus_endpoint_if #(
  parameter int DATA_W = 8
);
  logic              txn_valid;
  logic              txn_ready;
  logic [1:0]        opcode;
  logic [1:0]        source_id;
  logic [1:0]        dest_id;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              ack_valid;
  logic              ack_ready;
  logic [1:0]        ack_id;
  logic              ack_err;
  logic [1:0]        module_source_id;

  modport master (
    output txn_valid, opcode, source_id, dest_id, data_in, valid_in, data_ready, ack_ready,
    input  txn_ready, ready_in, data_out, data_valid, ack_valid, ack_id, ack_err, module_source_id
  );

  modport slave (
    input  txn_valid, opcode, source_id, dest_id, data_in, valid_in, data_ready, ack_ready,
    output txn_ready, ready_in, data_out, data_valid, ack_valid, ack_id, ack_err, module_source_id
  );
endinterface

// File: rtl/crypto_bus_endpoint.sv
// Generic bus endpoint that loads an input block, runs an attached core, streams back the result
// and acknowledges. Define CRYPTO_EP_TIMEOUT_EN to abort a core run after TIMEOUT cycles.
module crypto_bus_endpoint #(
  parameter int         DATA_W    = 8,
  parameter int         IN_WORDS  = 64,
  parameter int         OUT_WORDS = 32,
  parameter logic [1:0] MODULE_ID = 2'd1,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  crypto_bus_endpoint_if.slave          bus,
  output logic                          core_start,
  input  logic                          core_done,
  output logic [IN_WORDS*DATA_W-1:0]    blk_out,
  input  logic [OUT_WORDS*DATA_W-1:0]   res_in
);

  localparam int KW = $clog2(IN_WORDS + 1);
  localparam int JW = $clog2(OUT_WORDS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(IN_WORDS - 1);
  localparam logic [JW-1:0] J_LAST = JW'(OUT_WORDS - 1);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("crypto_bus_endpoint: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, RUN, READ, ACK} state_t;

  state_t                        state;
  logic [IN_WORDS*DATA_W-1:0]    in_buf;
  logic [OUT_WORDS*DATA_W-1:0]   res_buf;
  logic [KW-1:0]                 k;
  logic [JW-1:0]                 j;

`ifdef CRYPTO_EP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);
  logic [CW-1:0] cnt;
`endif

  assign blk_out              = in_buf;
  assign bus.module_source_id = MODULE_ID;

  // Word 0 lives in the MSBs of both buffers; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      in_buf         <= '0;
      res_buf        <= '0;
      k              <= '0;
      j              <= '0;
      bus.txn_ready  <= 1'b1;
      bus.ready_in   <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.data_out   <= '0;
      bus.ack_valid  <= 1'b0;
      bus.ack_err    <= 1'b0;
      bus.ack_id     <= '0;
      core_start     <= 1'b0;
`ifdef CRYPTO_EP_TIMEOUT_EN
      cnt            <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.txn_valid && bus.dest_id == MODULE_ID) begin
            bus.ack_id    <= bus.source_id;
            bus.txn_ready <= 1'b0;
            case (bus.opcode)
              2'b00: begin
                state        <= LOAD;
                bus.ready_in <= 1'b1;
                k            <= '0;
              end
              2'b01: begin
                state      <= RUN;
                core_start <= 1'b1;
`ifdef CRYPTO_EP_TIMEOUT_EN
                cnt        <= '0;
`endif
              end
              2'b10: begin
                state          <= READ;
                bus.data_valid <= 1'b1;
                bus.data_out   <= res_buf[(OUT_WORDS-1)*DATA_W +: DATA_W];
                j              <= '0;
              end
              default: begin
                state         <= ACK;
                bus.ack_valid <= 1'b1;
                bus.ack_err   <= 1'b1;
              end
            endcase
          end
        end

        LOAD: begin
          if (bus.valid_in) begin
            in_buf[(IN_WORDS-1-int'(k))*DATA_W +: DATA_W] <= bus.data_in;
            if (k == K_LAST) begin
              k             <= '0;
              bus.ready_in  <= 1'b0;
              bus.ack_valid <= 1'b1;
              bus.ack_err   <= 1'b0;
              state         <= ACK;
            end else begin
              k <= k + 1'b1;
            end
          end
        end

        // A done pulse that coincides with the start pulse belongs to a previous run and is ignored.
        RUN: begin
          if (!core_start && core_done) begin
            res_buf       <= res_in;
            bus.ack_valid <= 1'b1;
            bus.ack_err   <= 1'b0;
            state         <= ACK;
          end
`ifdef CRYPTO_EP_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            bus.ack_valid <= 1'b1;
            bus.ack_err   <= 1'b1;
            state         <= ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        READ: begin
          if (bus.data_ready) begin
            if (j == J_LAST) begin
              j              <= '0;
              bus.data_valid <= 1'b0;
              bus.ack_valid  <= 1'b1;
              bus.ack_err    <= 1'b0;
              state          <= ACK;
            end else begin
              j            <= j + 1'b1;
              bus.data_out <= res_buf[(OUT_WORDS-2-int'(j))*DATA_W +: DATA_W];
            end
          end
        end

        ACK: begin
          if (bus.ack_ready) begin
            bus.ack_valid <= 1'b0;
            bus.ack_err   <= 1'b0;
            bus.txn_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crypto_bus_endpoint.md
# crypto_bus_endpoint

Parametrised bus endpoint for the crypto accelerators. It accepts transactions from the shared transaction bus and loads a configurable-width, configurable-depth input block over the valid/ready data bus. It starts an attached core, captures the core's result, streams the result back out, and posts an acknowledge on the ACK bus. It is the generalised successor to the fixed 8-bit, single-purpose SHA bus front-end, and sits between the bus fabric and any core (SHA, AES) via flat block/result vectors.

## Interface
- DATA_W, 8, bus word width in bits (8, 16 or 32)
- IN_WORDS, 64, words per input block; width of `blk_out` is IN_WORDS*DATA_W
- OUT_WORDS, 32, words per result; width of `res_in` is OUT_WORDS*DATA_W
- MODULE_ID, 2'd1, this endpoint's bus ID
- TIMEOUT, 1024, core-run cycle limit (used only with CRYPTO_EP_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- txn_valid / txn_ready  in / out  1  transaction handshake
- opcode  in  2  00 LOAD, 01 RUN, 10 READ, 11 reserved
- source_id, dest_id  in  2  requester ID, target ID
- data_in  in  DATA_W  input word
- valid_in / ready_in  in / out  1  input handshake
- data_out  out  DATA_W  result word
- data_valid / data_ready  out / in  1  output handshake
- ack_valid / ack_ready  out / in  1  ack handshake
- ack_id  out  2  latched source_id of the transaction being acked
- ack_err  out  1  error flag qualifying ack_valid
- module_source_id  out  2  constant MODULE_ID
- core_start  out  1  one-cycle start pulse
- core_done  in  1  core completion pulse
- blk_out  out  IN_WORDS*DATA_W  input block; word 0 in the MSBs
- res_in  in  OUT_WORDS*DATA_W  core result; word 0 in the MSBs

## Operation
- States: IDLE, LOAD, RUN, READ, ACK.
- IDLE:
  - txn_ready=1.
  - On txn handshake with dest_id≠MODULE_ID: transaction consumed and dropped; stay IDLE, no ack.
  - Otherwise source_id is latched into ack_id.
  - Next state by opcode: 00→LOAD, 01→RUN, 10→READ, 11→ACK with ack_err=1.
- LOAD:
  - ready_in=1. Each handshake writes data_in to word index k (0..IN_WORDS-1); k increments.
  - Handshake on k=IN_WORDS-1 → ACK (ack_err=0); k returns to 0.
  - Words not written in a partial load keep their prior values.
- RUN:
  - core_start=1 in the first RUN cycle only.
  - core_done is sampled from the following cycle onward; a done coincident with core_start is ignored.
  - On core_done: res_in is latched into the result buffer → ACK (ack_err=0).
- READ:
  - data_out = result word j, data_valid=1. j advances on each handshake.
  - Handshake on j=OUT_WORDS-1 → ACK.
  - READ before any RUN returns the reset contents (all zero).
- ACK:
  - ack_valid=1 until ack_ready is sampled high.
  - Then → IDLE; ack_err clears.
- blk_out continuously reflects the input buffer.
- txn_valid while not in IDLE is ignored (txn_ready=0).

## Timing
- Reset (rst_n low at a clk edge):
  - State IDLE; both buffers, k and j zeroed.
  - Outputs: txn_ready=1; ready_in, data_valid, ack_valid, ack_err, core_start = 0; data_out=0; ack_id=0.
  - module_source_id=MODULE_ID.
- Reset mid-operation abandons the transaction; no ack is issued.
- Transaction accepted at edge T: new state active at T+1.
- LOAD throughput: one word per cycle. Last word at edge L: ack_valid=1 from L+1.
- RUN: core_start high during cycle T+1. core_done at edge D: ack_valid from D+1.
- READ: data_out is registered. Word 0 is valid in cycle T+1; back-to-back handshakes give one word per cycle.
- Ack accepted at edge A: txn_ready=1 from A+1. Minimum turnaround is one idle cycle per transaction.
- Stalls: valid_in low, or data_ready low, holds k/j and data_out unchanged.

## Configuration
- CRYPTO_EP_TIMEOUT_EN defined:
  - A counter runs in RUN.
  - If core_done has not arrived TIMEOUT cycles after core_start: → ACK with ack_err=1. The result buffer is unchanged.
  - A core_done arriving in the same cycle as expiry wins (no error).
- Undefined: RUN waits indefinitely; ack_err is asserted only for opcode 11.

## Test plan
- DATA_W=8, IN_WORDS=4, dest 1: LOAD 0x11,0x22,0x33,0x44 → blk_out=0x11223344; ack_id=source_id, ack_err=0, ack one cycle after last word.
- RUN with core_done 5 cycles after core_start, res_in=0xDEADBEEF (OUT_WORDS=4) → READ yields DE,AD,BE,EF; data_ready toggled every other cycle, no word lost or repeated.
- dest_id=2 with MODULE_ID=1, opcode LOAD → no ready_in, no ack, txn_ready stays 1; opcode 11 to dest 1 → ack_err=1.
- rst_n low after 2 of 4 LOAD words → all outputs at reset values, blk_out=0; a fresh LOAD completes normally.
- ack_ready held low 10 cycles → ack_valid and ack_id stable, txn_ready=0 throughout.
- With CRYPTO_EP_TIMEOUT_EN, TIMEOUT=8, no core_done → ack_err=1 at cycle 9 after core_start; without the macro → no ack after 100 cycles.
